// File: rtl/way_hit_select_pkg.sv
// way_hit_select_pkg
//   Shared constants and helpers for the 4-way tag-match / way-select stage.
//   NUM_WAYS      : way count (the datapath only supports 4)
//   WAY_IDX_BITS  : encoded way index width
//   DEF_TAG_BITS  : default tag width
//   DEF_LINE_BITS : default line data width
//   prio_enc()    : match vector -> lowest-numbered set bit (0 when empty)
package way_hit_select_pkg;

    localparam int NUM_WAYS      = 4;
    localparam int WAY_IDX_BITS  = 2;
    localparam int DEF_TAG_BITS  = 18;
    localparam int DEF_LINE_BITS = 32;

    // Walk from the top down so the lowest set bit is the last one written.
    function automatic logic [WAY_IDX_BITS-1:0] prio_enc(input logic [NUM_WAYS-1:0] vec);
        logic [WAY_IDX_BITS-1:0] idx;
        idx = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (vec[i]) idx = WAY_IDX_BITS'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/way_hit_select_tag_cmp.sv
// tag_cmp
//   One way's qualified tag match: tag equality ANDed with the way valid bit.
//   Ports:
//     tag     in  TAG_BITS  request tag
//     way_tag in  TAG_BITS  stored tag of this way
//     valid   in  1         way valid bit
//     match   out 1         tag equal and valid
module tag_cmp #(
    parameter int TAG_BITS = 18
) (
    input  logic [TAG_BITS-1:0] tag,
    input  logic [TAG_BITS-1:0] way_tag,
    input  logic                valid,
    output logic                match
);

    assign match = (tag == way_tag) && valid;

endmodule

// File: rtl/way_hit_select.sv
// way_hit_select
//   Tag-match and way-select stage of the 4-way set-associative cache.
//   Per-way qualified match, lowest-way priority select of the line, all
//   results registered (latency 1, one request per cycle, no stall).
//   Optional macro WAY_HIT_SELECT_MULTIHIT_CHECK_EN: when defined, o_multi_hit
//   flags requests where more than one way matched; otherwise it is tied to 0.
//   Ports:
//     clk, rst      clock (rising) / async active-high reset
//     i_req         lookup strobe; results captured when high
//     i_tag         request tag
//     i_way_tag     stored tags, way w at [w*TAG_BITS +: TAG_BITS]
//     i_way_valid   per-way valid
//     i_way_line    stored lines, way w at [w*LINE_BITS +: LINE_BITS]
//     o_rsp         one-cycle result strobe
//     o_hit         any way matched
//     o_hit_onehot  all qualified matches, unmasked
//     o_hit_idx     lowest matching way (0 on miss)
//     o_line        line of o_hit_idx, zero on miss
//     o_multi_hit   more than one way matched (macro-dependent)
module way_hit_select
    import way_hit_select_pkg::*;
#(
    parameter int TAG_BITS  = DEF_TAG_BITS,
    parameter int LINE_BITS = DEF_LINE_BITS,
    parameter int WAYS      = NUM_WAYS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req,
    input  logic [TAG_BITS-1:0]       i_tag,
    input  logic [WAYS*TAG_BITS-1:0]  i_way_tag,
    input  logic [WAYS-1:0]           i_way_valid,
    input  logic [WAYS*LINE_BITS-1:0] i_way_line,
    output logic                      o_rsp,
    output logic                      o_hit,
    output logic [WAYS-1:0]           o_hit_onehot,
    output logic [WAY_IDX_BITS-1:0]   o_hit_idx,
    output logic [LINE_BITS-1:0]      o_line,
    output logic                      o_multi_hit
);

    if (WAYS != NUM_WAYS) begin : g_ways_chk
        $error("way_hit_select: WAYS must be 4");
    end

    logic [WAYS-1:0]      match;
    logic [WAYS-1:0]      sel;
    logic [LINE_BITS-1:0] line_mux;

    for (genvar w = 0; w < WAYS; w++) begin : g_cmp
        tag_cmp #(.TAG_BITS(TAG_BITS)) u_cmp (
            .tag    (i_tag),
            .way_tag(i_way_tag[w*TAG_BITS +: TAG_BITS]),
            .valid  (i_way_valid[w]),
            .match  (match[w])
        );
    end

    // Isolate the lowest set match bit so the AND-OR mux below only ever
    // sees a single selected way, even on a multi-hit.
    assign sel = match & (~match + WAYS'(1));

    always_comb begin
        line_mux = '0;
        for (int w = 0; w < WAYS; w++) begin
            line_mux = line_mux | ({LINE_BITS{sel[w]}} & i_way_line[w*LINE_BITS +: LINE_BITS]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rsp        <= 1'b0;
            o_hit        <= 1'b0;
            o_hit_onehot <= '0;
            o_hit_idx    <= '0;
            o_line       <= '0;
        end else begin
            o_rsp <= i_req;
            if (i_req) begin
                o_hit        <= |match;
                o_hit_onehot <= match;
                o_hit_idx    <= prio_enc(match);
                o_line       <= line_mux;
            end
        end
    end

`ifdef WAY_HIT_SELECT_MULTIHIT_CHECK_EN
    logic [2:0] match_cnt;

    always_comb begin
        match_cnt = '0;
        for (int w = 0; w < WAYS; w++) begin
            match_cnt = match_cnt + 3'(match[w]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        o_multi_hit <= 1'b0;
        else if (i_req) o_multi_hit <= (match_cnt > 3'd1);
    end
`else
    assign o_multi_hit = 1'b0;
`endif

endmodule

// File: tb/tb_way_hit_select.sv
module tb_way_hit_select;
    localparam int TB = 18;
    localparam int LB = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic [TB-1:0] tag = '0;
    logic [TB-1:0] tags [4];
    logic [LB-1:0] lines[4];
    logic [3:0]    valid = '0;

    logic          rsp, hit, multi;
    logic [3:0]    onehot;
    logic [1:0]    idx;
    logic [LB-1:0] line;

    int checks   = 0;
    int failures = 0;

    // model expectations
    logic          e_rsp, e_hit, e_multi;
    logic [3:0]    e_onehot;
    logic [1:0]    e_idx;
    logic [LB-1:0] e_line;

    always #5 clk = ~clk;

    way_hit_select dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (req),
        .i_tag       (tag),
        .i_way_tag   ({tags[3], tags[2], tags[1], tags[0]}),
        .i_way_valid (valid),
        .i_way_line  ({lines[3], lines[2], lines[1], lines[0]}),
        .o_rsp       (rsp),
        .o_hit       (hit),
        .o_hit_onehot(onehot),
        .o_hit_idx   (idx),
        .o_line      (line),
        .o_multi_hit (multi)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Behavioural reference: evaluate the lookup rules on the sampled inputs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_rsp = 0; e_hit = 0; e_multi = 0; e_onehot = 0; e_idx = 0; e_line = 0;
        end else begin
            e_rsp = req;
            if (req) begin
                int n;
                bit found;
                n = 0; found = 0;
                e_onehot = 0; e_idx = 0; e_line = 0;
                for (int w = 0; w < 4; w++) begin
                    if (valid[w] && tags[w] == tag) begin
                        e_onehot[w] = 1'b1;
                        n++;
                        if (!found) begin
                            found  = 1;
                            e_idx  = 2'(w);
                            e_line = lines[w];
                        end
                    end
                end
                e_hit = found;
`ifdef WAY_HIT_SELECT_MULTIHIT_CHECK_EN
                e_multi = (n > 1);
`else
                e_multi = 0;
`endif
            end
        end
    end

    // Compare process: outputs are meaningful every cycle (hold when idle).
    always @(negedge clk) begin
        check("m_rsp", 64'(rsp), 64'(e_rsp));
        check("m_hit", 64'(hit), 64'(e_hit));
        check("m_onehot", 64'(onehot), 64'(e_onehot));
        check("m_idx", 64'(idx), 64'(e_idx));
        check("m_line", 64'(line), 64'(e_line));
        check("m_multi", 64'(multi), 64'(e_multi));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_base();
        for (int w = 0; w < 4; w++) begin
            tags[w]  = TB'(w);
            lines[w] = LB'(w);
        end
        valid = 4'b1111;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int w = 0; w < 4; w++) begin tags[w] = '0; lines[w] = '0; end
        #1;
        check("reset_rsp", 64'(rsp), 64'd0);
        check("reset_line", 64'(line), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // single hit
        @(negedge clk); set_base(); tag = 18'h00002; req = 1;
        cyc();
        check("single_rsp", 64'(rsp), 64'd1);
        check("single_hit", 64'(hit), 64'd1);
        check("single_onehot", 64'(onehot), 64'b0100);
        check("single_idx", 64'(idx), 64'd2);
        check("single_line", 64'(line), 64'h2);

        // tag-equal but invalid way
        @(negedge clk); valid = 4'b1011;
        cyc();
        check("inval_hit", 64'(hit), 64'd0);
        check("inval_onehot", 64'(onehot), 64'd0);
        check("inval_line", 64'(line), 64'd0);

        // multi-hit, lowest way wins
        @(negedge clk); set_base();
        tags[1] = 18'h3FFFF; tags[3] = 18'h3FFFF;
        lines[1] = 32'hAAAA5555; lines[3] = 32'h12345678; tag = 18'h3FFFF;
        cyc();
        check("multi_onehot", 64'(onehot), 64'b1010);
        check("multi_idx", 64'(idx), 64'd1);
        check("multi_line", 64'(line), 64'hAAAA5555);
`ifdef WAY_HIT_SELECT_MULTIHIT_CHECK_EN
        check("multi_flag", 64'(multi), 64'd1);
`else
        check("multi_flag", 64'(multi), 64'd0);
`endif

        // back-to-back
        @(negedge clk); set_base(); tag = 18'h0;
        cyc();
        check("b2b0_rsp", 64'(rsp), 64'd1); check("b2b0_hit", 64'(hit), 64'd1); check("b2b0_idx", 64'(idx), 64'd0);
        @(negedge clk); tag = 18'h5;
        cyc();
        check("b2b1_rsp", 64'(rsp), 64'd1); check("b2b1_hit", 64'(hit), 64'd0); check("b2b1_idx", 64'(idx), 64'd0);
        @(negedge clk); tag = 18'h3;
        cyc();
        check("b2b2_rsp", 64'(rsp), 64'd1); check("b2b2_hit", 64'(hit), 64'd1); check("b2b2_idx", 64'(idx), 64'd3);
        check("b2b2_line", 64'(line), 64'h3);

        // hold while idle and inputs change
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); req = 0; tag = TB'($urandom);
            for (int w = 0; w < 4; w++) lines[w] = $urandom;
            cyc();
            check("hold_rsp", 64'(rsp), 64'd0);
            check("hold_line", 64'(line), 64'h3);
            check("hold_idx", 64'(idx), 64'd3);
        end

        // randomized traffic; small tag space so hits and multi-hits occur
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            req   = ($urandom_range(0, 3) != 0);
            tag   = TB'($urandom_range(0, 3)) | (($urandom_range(0, 7) == 0) ? 18'h20000 : 18'h0);
            valid = 4'($urandom);
            for (int w = 0; w < 4; w++) begin
                tags[w]  = TB'($urandom_range(0, 3));
                lines[w] = $urandom;
            end
        end

        // async reset mid-cycle with a request pending
        @(negedge clk); set_base(); tag = 18'h1; req = 1;
        cyc();
        check("pre_rst_hit", 64'(hit), 64'd1);
        @(negedge clk); tag = 18'h2; req = 1;
        #2 rst = 1;
        #1;
        check("rst_rsp", 64'(rsp), 64'd0);
        check("rst_hit", 64'(hit), 64'd0);
        check("rst_onehot", 64'(onehot), 64'd0);
        check("rst_idx", 64'(idx), 64'd0);
        check("rst_line", 64'(line), 64'd0);
        check("rst_multi", 64'(multi), 64'd0);
        @(negedge clk); rst = 0; req = 0;
        cyc();
        check("post_rst_rsp", 64'(rsp), 64'd0);
        check("post_rst_line", 64'(line), 64'd0);
        cyc();

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
